// File: rtl/codecheck.sv
// Receive-side checker for an incrementing-code stream (0 .. 2**DATA_WIDTH-1).
// Optional macro CODECHECK_RESYNC_EN re-locks the expected value to the received word after a mismatch.
module codecheck #(
    parameter int DATA_WIDTH  = 8,
    parameter int ERR_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  arm,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_WIDTH-1:0] LAST_IDX   = '1;
    localparam logic [DATA_WIDTH-1:0] ONE_D      = 1;
    localparam logic [ERR_W-1:0]      ERR_MAX    = '1;
    localparam logic [ERR_W-1:0]      ONE_E      = 1;
    localparam logic [IDLE_W-1:0]     ONE_I      = 1;
    localparam logic [IDLE_W-1:0]     IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   expected_q, expected_d;
    logic [DATA_WIDTH-1:0]   idx_q, idx_d;
    logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
    logic [DATA_WIDTH-1:0]   first_err_exp_q, first_err_exp_d;
    logic [DATA_WIDTH-1:0]   first_err_got_q, first_err_got_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic                    mismatch;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q         <= IDLE;
            expected_q      <= '0;
            idx_q           <= '0;
            idle_cnt_q      <= '0;
            err_cnt_q       <= '0;
            first_err_exp_q <= '0;
            first_err_got_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            expected_q      <= expected_d;
            idx_q           <= idx_d;
            idle_cnt_q      <= idle_cnt_d;
            err_cnt_q       <= err_cnt_d;
            first_err_exp_q <= first_err_exp_d;
            first_err_got_q <= first_err_got_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            timeout_q       <= timeout_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        expected_d      = expected_q;
        idx_d           = idx_q;
        idle_cnt_d      = idle_cnt_q;
        err_cnt_d       = err_cnt_q;
        first_err_exp_d = first_err_exp_q;
        first_err_got_d = first_err_got_q;
        busy_d          = busy_q;
        done_d          = done_q;
        pass_d          = pass_q;
        timeout_d       = timeout_q;
        mismatch        = (in_data != expected_q);

        case (state_q)
            RUN: begin
                if (in_valid) begin
                    idle_cnt_d = '0;
                    idx_d      = idx_q + ONE_D;
                    expected_d = expected_q + ONE_D;
                    if (mismatch) begin
                        // err_cnt_q is still zero only until the first mismatch, even after saturation
                        if (err_cnt_q == '0) begin
                            first_err_exp_d = expected_q;
                            first_err_got_d = in_data;
                        end
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ONE_E;
                        end
`ifdef CODECHECK_RESYNC_EN
                        expected_d = in_data + ONE_D;
`else
                        expected_d = expected_q + ONE_D;
`endif
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == '0);
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = DONE;
                    idle_cnt_d = idle_cnt_q + ONE_I;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                    pass_d     = 1'b0;
                end else begin
                    idle_cnt_d = idle_cnt_q + ONE_I;
                end
            end
            default: begin
            end
        endcase

        // arm restarts from any state and wins over a same-cycle sample
        if (arm) begin
            state_d         = RUN;
            expected_d      = '0;
            idx_d           = '0;
            idle_cnt_d      = '0;
            err_cnt_d       = '0;
            first_err_exp_d = '0;
            first_err_got_d = '0;
            busy_d          = 1'b1;
            done_d          = 1'b0;
            pass_d          = 1'b0;
            timeout_d       = 1'b0;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_exp = first_err_exp_q;
    assign first_err_got = first_err_got_q;

endmodule

// File: tb/tb_codecheck.sv
// Directed testbench for codecheck (DATA_WIDTH=8, ERR_W=4, TIMEOUT_CYC=16).
module tb_codecheck;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       arm = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       busy, done, pass, timeout;
    logic [3:0] err_cnt;
    logic [7:0] first_err_exp, first_err_got;

    int vectorCount = 0;
    int missCount   = 0;

`ifdef CODECHECK_RESYNC_EN
    localparam int T2_ERRS = 2;
`else
    localparam int T2_ERRS = 1;
`endif

    codecheck #(.DATA_WIDTH(8), .ERR_W(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_l(rst_l), .arm(arm), .in_valid(in_valid), .in_data(in_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge, so every call also observes the previous rising edge
    task automatic applyStimulus(input logic a, input logic v, input logic [7:0] d);
        @(negedge clk);
        arm      = a;
        in_valid = v;
        in_data  = d;
    endtask

    task automatic sendSamples(input int first, input int last, input int badIdx,
                               input logic [7:0] badVal, input bit gaps);
        for (int i = first; i <= last; i++) begin
            applyStimulus(1'b0, 1'b1, (i == badIdx) ? badVal : 8'(i));
            if (gaps) applyStimulus(1'b0, 1'b0, 8'h00);
        end
    endtask

    initial begin
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err_cnt, 0);
        @(negedge clk);
        rst_l = 1'b1;

        // samples in IDLE are ignored
        sendSamples(0, 3, 1, 8'hEE, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_err", err_cnt, 0);

        // test 1: clean stream, done one cycle after the last sample
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendSamples(0, 254, -1, 8'h00, 0);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checkOutput("t1_busy_before", busy, 1);
        checkOutput("t1_done_before", done, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_pass", pass, 1);
        checkOutput("t1_err", err_cnt, 0);
        checkOutput("t1_timeout", timeout, 0);
        checkOutput("t1_busy", busy, 0);
        applyStimulus(1'b0, 1'b1, 8'h55);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t1_hold_err", err_cnt, 0);
        checkOutput("t1_hold_done", done, 1);

        // test 2: one corrupted word at index 0x20
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendSamples(0, 255, 32, 8'h10, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t2_done", done, 1);
        checkOutput("t2_pass", pass, 0);
        checkOutput("t2_err", err_cnt, T2_ERRS);
        checkOutput("t2_exp", first_err_exp, 8'h20);
        checkOutput("t2_got", first_err_got, 8'h10);

        // test 3: in_valid every other cycle
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendSamples(0, 255, -1, 8'h00, 1);
        checkOutput("t3_done", done, 1);
        checkOutput("t3_pass", pass, 1);
        checkOutput("t3_timeout", timeout, 0);
        checkOutput("t3_err", err_cnt, 0);

        // test 4: stream stops after sample 100, timeout on 16th idle edge
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendSamples(0, 100, -1, 8'h00, 0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t4_busy_15", busy, 1);
        checkOutput("t4_done_15", done, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t4_done", done, 1);
        checkOutput("t4_timeout", timeout, 1);
        checkOutput("t4_pass", pass, 0);
        checkOutput("t4_err", err_cnt, 0);
        checkOutput("t4_busy", busy, 0);

        // test 5: asynchronous reset mid-run, then arm mid-run with a colliding sample
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendSamples(0, 49, 10, 8'h99, 0);
        @(posedge clk);
        #2 rst_l = 1'b0;
        #1;
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_err", err_cnt, 0);
        checkOutput("t5_rst_fexp", first_err_exp, 0);
        checkOutput("t5_rst_fgot", first_err_got, 0);
        @(negedge clk);
        rst_l = 1'b1;
        sendSamples(0, 3, -1, 8'h00, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t5_noarm_busy", busy, 0);
        checkOutput("t5_noarm_done", done, 0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendSamples(0, 199, 5, 8'h77, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t5_pre_err", err_cnt, 1);
        applyStimulus(1'b1, 1'b1, 8'd200);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("t5_rearm_busy", busy, 1);
        checkOutput("t5_rearm_err", err_cnt, 0);
        checkOutput("t5_rearm_fgot", first_err_got, 0);
        sendSamples(1, 254, -1, 8'h00, 0);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checkOutput("t5_done_before", done, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t5_done", done, 1);
        checkOutput("t5_pass", pass, 1);

        // test 6: constant 0xAA saturates the 4-bit error counter
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) applyStimulus(1'b0, 1'b1, 8'hAA);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("t6_err", err_cnt, 15);
        checkOutput("t6_done", done, 1);
        checkOutput("t6_pass", pass, 0);
        checkOutput("t6_exp", first_err_exp, 8'h00);
        checkOutput("t6_got", first_err_got, 8'hAA);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
